// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: MemOp encoding and store-buffer entry layout.
// Imported by the store buffer, its FIFO, and the bench.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEMOP_B  = 2'b00,
    MEMOP_H  = 2'b01,
    MEMOP_W  = 2'b10,
    MEMOP_BU = 2'b11
  } memop_e;

  // Entry = {addr, wd[31:0], op[1:0]}; this is the non-address part.
  localparam int SB_META_W = 34;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer storage: circular FIFO with count, per-entry valid, addr taps.
// Ports: clk, rst, push/push_data, pop, head_data, count, valid, addrs.
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int W     = AW + 34,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [CW-1:0]              count,
  output logic [DEPTH-1:0]           valid,
  output logic [DEPTH-1:0][AW-1:0]   addrs
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  // push never targets the head slot while popping:
  // push needs count<DEPTH, pop needs count>0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (pop) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[head];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addrs[i] = mem[i][W-1 -: AW];
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port data memory.
// Ports: store in (st_*), load in/out (ld_*), memory port (mem_*), status.
import riscv_pkg::*;

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int W    = AW + SB_META_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_wd,
  input  logic [1:0]    st_op,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [1:0]    ld_op,
  output logic          ld_stall,
  output logic [31:0]   ld_rd,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [1:0]    mem_op,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,
  output logic          sb_empty,
  output logic [CW-1:0] sb_count
);

  logic                     push;
  logic                     pop;
  logic [W-1:0]             head;
  logic [CW-1:0]            count;
  logic [DEPTH-1:0]         valid;
  logic [DEPTH-1:0][AW-1:0] addrs;
  logic [DEPTH-1:0]         hit;
  logic                     hazard;
  logic                     full;
  logic                     grant_ld;
  logic                     drain;

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({st_addr, st_wd, st_op}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .valid     (valid),
    .addrs     (addrs)
  );

  // Word-granular match: byte offset bits are ignored.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] &&
               (((addrs[i] ^ ld_addr) >> 2) == '0);
    end
  end

  assign hazard   = ld_valid && (|hit);
  assign full     = (count == CW'(DEPTH));
  assign st_ready = !full;
  assign push     = st_valid && st_ready;

  // Full buffer always drains first so loads
  // cannot starve the store stream.
  assign grant_ld = ld_valid && !hazard &&
                    !full && mem_ready;
  assign drain    = !grant_ld && (count != '0) &&
                    mem_ready;

  always_comb begin
    mem_we   = 1'b0;
    mem_a    = ld_addr;
    mem_op   = ld_op;
    mem_wd   = head[33:2];
    ld_stall = ld_valid;
    pop      = 1'b0;
    unique case (1'b1)
      grant_ld: begin
        ld_stall = 1'b0;
      end
      drain: begin
        mem_we = 1'b1;
        mem_a  = head[W-1 -: AW];
        mem_op = head[1:0];
        pop    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ld_rd    = mem_rd;
  assign sb_empty = (count == '0);
  assign sb_count = count;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue model + word memory, directed scenarios.
// Ports: drives all DUT inputs, models the data memory behind mem_*.
`timescale 1ns/1ps
import riscv_pkg::*;

module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_wd;
  logic [1:0]  st_op;
  logic        ld_valid, ld_stall;
  logic [31:0] ld_addr, ld_rd;
  logic [1:0]  ld_op;
  logic        mem_ready, mem_we;
  logic [1:0]  mem_op;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  op;
  } st_t;

  st_t         q[$];
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_wd(st_wd), .st_op(st_op),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_op(ld_op), .ld_stall(ld_stall), .ld_rd(ld_rd),
    .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_op(mem_op), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .sb_empty(sb_empty),
    .sb_count(sb_count)
  );

  function automatic logic [31:0] merge(
    logic [31:0] old, logic [31:0] a,
    logic [31:0] d, logic [1:0] op);
    logic [31:0] r = old;
    case (op)
      2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
      2'b10:   r = d;
      default: r[{a[1:0], 3'b000} +: 8] = d[7:0];
    endcase
    return r;
  endfunction

  // Data memory: combinational read, write on posedge.
  assign mem_rd = tb_mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we === 1'b1)
      tb_mem[mem_a[9:2]] = merge(tb_mem[mem_a[9:2]],
                                 mem_a, mem_wd, mem_op);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Arbitration outcome from the pending-store list.
  function automatic void decide(output bit eld,
                                 output bit edr);
    bit haz = 0;
    int n = q.size();
    foreach (q[i])
      if (q[i].a[31:2] == ld_addr[31:2]) haz = ld_valid;
    eld = ld_valid && !haz && n < DEPTH && mem_ready;
    edr = !eld && n > 0 && mem_ready;
  endfunction

  always @(posedge clk) begin
    bit eld, edr;
    int n;
    if (!rst) begin
      q.delete();
    end else begin
      n = q.size();
      decide(eld, edr);
      if (edr) begin
        ref_mem[q[0].a[9:2]] = merge(ref_mem[q[0].a[9:2]],
                                     q[0].a, q[0].d, q[0].op);
        void'(q.pop_front());
      end
      if (st_valid && n < DEPTH)
        q.push_back('{st_addr, st_wd, st_op});
    end
  end

  always @(negedge clk) begin
    bit eld, edr;
    int n;
    if (rst === 1'b1) begin
      n = q.size();
      decide(eld, edr);
      chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
      chk("sb_count", 32'(sb_count), 32'(n));
      chk("sb_empty", 32'(sb_empty), 32'(n == 0));
      chk("mem_we", 32'(mem_we), 32'(edr));
      chk("ld_stall", 32'(ld_stall), 32'(ld_valid && !eld));
      if (edr) begin
        chk("drain_a", mem_a, q[0].a);
        chk("drain_wd", mem_wd, q[0].d);
        chk("drain_op", 32'(mem_op), 32'(q[0].op));
      end else begin
        chk("port_a", mem_a, ld_addr);
        chk("port_op", 32'(mem_op), 32'(ld_op));
      end
      if (eld) chk("ld_rd", ld_rd, ref_mem[ld_addr[9:2]]);
    end
  end

  always @(negedge clk)
    assert (!(st_valid && ld_valid))
      else $error("store and load presented together");

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0] op);
    bit acc = 0;
    st_valid = 1; st_addr = a; st_wd = d; st_op = op;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = st_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("store_timeout", 0, 1);
    st_valid = 0;
  endtask

  task automatic load(input logic [31:0] a,
                      input logic [1:0] op);
    bit got = 0;
    mem_ready = 1;
    ld_valid = 1; ld_addr = a; ld_op = op;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = !ld_stall;
      @(posedge clk); #1;
    end
    if (!got) chk("load_timeout", 0, 1);
    ld_valid = 0;
  endtask

  task automatic wait_empty();
    bit e = 0;
    for (int i = 0; i < 50 && !e; i++) begin
      @(negedge clk);
      e = sb_empty;
    end
    chk("drained", 32'(e), 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          ld;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  op;
    bit          mr;
  } vec_t;

  vec_t vt[12] = '{
    '{0, 32'h202, 32'h1234,     MEMOP_H,  0},
    '{0, 32'h203, 32'h56,       MEMOP_B,  0},
    '{0, 32'h210, 32'hCAFEF00D, MEMOP_W,  1},
    '{1, 32'h200, 32'h0,        MEMOP_W,  1},
    '{0, 32'h214, 32'h9A,       MEMOP_B,  0},
    '{0, 32'h216, 32'h7788,     MEMOP_H,  0},
    '{1, 32'h208, 32'h0,        MEMOP_B,  1},
    '{1, 32'h214, 32'h0,        MEMOP_W,  1},
    '{0, 32'h218, 32'h0BADF00D, MEMOP_W,  1},
    '{1, 32'h21B, 32'h0,        MEMOP_BU, 1},
    '{1, 32'h202, 32'h0,        MEMOP_H,  1},
    '{1, 32'h100, 32'h0,        MEMOP_W,  1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'hA500_0000 + i;
      ref_mem[i] = 32'hA500_0000 + i;
    end
    rst = 0; st_valid = 0; st_addr = 0; st_wd = 0;
    st_op = 0; ld_valid = 0; ld_addr = 0; ld_op = 0;
    mem_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_empty", 32'(sb_empty), 1);
    chk("rst_count", 32'(sb_count), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_stall", 32'(ld_stall), 0);
    @(posedge clk); #1 rst = 1;

    // Single sw drains the next cycle
    store(32'h10, 32'hDEADBEEF, MEMOP_W);
    @(negedge clk);
    chk("t2_we", 32'(mem_we), 1);
    chk("t2_a", mem_a, 32'h10);
    chk("t2_wd", mem_wd, 32'hDEADBEEF);
    chk("t2_op", 32'(mem_op), 32'(MEMOP_W));
    @(negedge clk);
    chk("t2_empty", 32'(sb_empty), 1);

    // Load to another word bypasses a queued store
    @(posedge clk); #1 mem_ready = 0;
    store(32'h40, 32'h11223344, MEMOP_W);
    mem_ready = 1; ld_valid = 1;
    ld_addr = 32'h80; ld_op = MEMOP_W;
    @(negedge clk);
    chk("t5_stall", 32'(ld_stall), 0);
    chk("t5_we", 32'(mem_we), 0);
    chk("t5_rd", ld_rd, 32'hA500_0020);
    @(posedge clk); #1 ld_valid = 0;
    @(negedge clk);
    chk("t5_drain_we", 32'(mem_we), 1);
    chk("t5_drain_a", mem_a, 32'h40);

    // Hazard: lw 0x20 waits for sb 0x21
    @(posedge clk); #1;
    store(32'h21, 32'hAB, MEMOP_B);
    ld_valid = 1; ld_addr = 32'h20; ld_op = MEMOP_W;
    @(negedge clk);
    chk("t4_stall", 32'(ld_stall), 1);
    chk("t4_we", 32'(mem_we), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_stall2", 32'(ld_stall), 0);
    chk("t4_rd", ld_rd, 32'hA500_AB08);
    @(posedge clk); #1 ld_valid = 0;

    // Fill with port blocked, 5th store held
    mem_ready = 0;
    for (int i = 0; i < 4; i++)
      store(32'h100 + 4 * i, i + 1, MEMOP_W);
    st_valid = 1; st_addr = 32'h110;
    st_wd = 5; st_op = MEMOP_W;
    @(negedge clk);
    chk("t3_full_rdy", 32'(st_ready), 0);
    chk("t3_full_cnt", 32'(sb_count), 4);
    @(posedge clk); #1 mem_ready = 1;
    @(negedge clk);
    chk("t3_a0", mem_a, 32'h100);
    chk("t3_rdy0", 32'(st_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_a1", mem_a, 32'h104);
    chk("t3_rdy1", 32'(st_ready), 1);
    @(posedge clk); #1 st_valid = 0;
    @(negedge clk); chk("t3_a2", mem_a, 32'h108);
    @(negedge clk); chk("t3_a3", mem_a, 32'h10C);
    @(negedge clk); chk("t3_a4", mem_a, 32'h110);
    @(negedge clk); chk("t3_empty", 32'(sb_empty), 1);

    // Full buffer drains ahead of a clean load
    @(posedge clk); #1 mem_ready = 0;
    for (int i = 0; i < 4; i++)
      store(32'h140 + 4 * i, 32'h50 + i, MEMOP_W);
    mem_ready = 1; ld_valid = 1;
    ld_addr = 32'h84; ld_op = MEMOP_W;
    @(negedge clk);
    chk("t6_stall", 32'(ld_stall), 1);
    chk("t6_we", 32'(mem_we), 1);
    chk("t6_cnt", 32'(sb_count), 4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_cnt2", 32'(sb_count), 3);
    chk("t6_stall2", 32'(ld_stall), 0);
    chk("t6_rd", ld_rd, 32'hA500_0021);
    @(posedge clk); #1 ld_valid = 0;
    wait_empty();

    // Mixed directed sequence, checked by the model
    foreach (vt[i]) begin
      if (vt[i].ld) begin
        load(vt[i].a, vt[i].op);
      end else begin
        mem_ready = vt[i].mr;
        store(vt[i].a, vt[i].d, vt[i].op);
      end
    end
    mem_ready = 1;
    wait_empty();

    // Reset while draining three entries
    mem_ready = 0;
    store(32'h300, 32'h1, MEMOP_W);
    store(32'h304, 32'h2, MEMOP_W);
    store(32'h308, 32'h3, MEMOP_W);
    mem_ready = 1;
    @(negedge clk);
    chk("t1_we", 32'(mem_we), 1);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("t1_count", 32'(sb_count), 0);
    chk("t1_empty", 32'(sb_empty), 1);
    chk("t1_we0", 32'(mem_we), 0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
